// File: rtl/fpu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// fpu_rr_arbiter
//
// Shares a single FPU datapath between NREQ requesters. A round-robin grant is
// made in IDLE, the winner's operands are registered onto the FPU operand bus,
// the FPU gets a single-cycle start pulse, the result is captured FPU_LAT
// cycles later and held on the response channel until it is consumed. The FPU
// is never restarted while an operation is outstanding.
//
// Parameters:
//   NREQ     number of requesters (2..8)
//   FPU_LAT  cycles from the start-pulse cycle to a valid FPU result (>=1)
//   IDW      width of resp_id, 2**IDW >= NREQ
//
// Ports:
//   clk, reset                 clock (rising edge), async active-low reset
//   req_valid/req_ready        per-requester request handshake (ready one-hot)
//   req_a/req_b                packed 32-bit operands, lane i = [32i+31:32i]
//   req_sel/req_round          packed 2-bit op select, 1-bit round mode
//   resp_valid/resp_ready      response handshake
//   resp_id/resp_y             owning requester index and result
//   resp_error/resp_ovf        FPU flags captured with the result
//   fpu_a/fpu_b/fpu_sel/
//   fpu_round/fpu_start        registered drive into the FPU
//   fpu_y/fpu_error/fpu_ovf    FPU result and flags
//   busy                       high whenever the FSM is not in IDLE
//
// Optional build macro FPU_RR_ARB_STATS_EN adds:
//   stat_ops   16-bit count of response handshakes (wraps)
//   stat_errs  16-bit count of handshakes carrying error or overflow (wraps)
// -----------------------------------------------------------------------------
module fpu_rr_arbiter #(
  parameter int NREQ    = 4,
  parameter int FPU_LAT = 4,
  parameter int IDW     = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [2*NREQ-1:0]    req_sel,
  input  logic [NREQ-1:0]      req_round,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [IDW-1:0]       resp_id,
  output logic [31:0]          resp_y,
  output logic                 resp_error,
  output logic                 resp_ovf,
  output logic [31:0]          fpu_a,
  output logic [31:0]          fpu_b,
  output logic [1:0]           fpu_sel,
  output logic                 fpu_round,
  output logic                 fpu_start,
  input  logic [31:0]          fpu_y,
  input  logic                 fpu_error,
  input  logic                 fpu_ovf,
  output logic                 busy
`ifdef FPU_RR_ARB_STATS_EN
  ,
  output logic [15:0]          stat_ops,
  output logic [15:0]          stat_errs
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [PW-1:0]   r_rr_ptr;
  logic [PW-1:0]   r_gnt;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_fpu_a;
  logic [31:0]     r_fpu_b;
  logic [1:0]      r_fpu_sel;
  logic            r_fpu_round;
  logic            r_fpu_start;
  logic            r_resp_valid;
  logic [IDW-1:0]  r_resp_id;
  logic [31:0]     r_resp_y;
  logic            r_resp_err;
  logic            r_resp_ovf;

  logic [PW-1:0]   w_idx;
  logic            w_hit;
  logic            w_found;
  logic [PW-1:0]   w_gnt_idx;
  logic [NREQ-1:0] w_req_ready;
  logic            w_accept;

`ifdef FPU_RR_ARB_STATS_EN
  logic [15:0]     r_stat_ops;
  logic [15:0]     r_stat_errs;
`endif

  // Round-robin search: first valid requester starting at r_rr_ptr, wrapping.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    w_idx     = '0;
    w_hit     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx     = PW'((int'(r_rr_ptr) + k) % NREQ);
      w_hit     = !w_found && req_valid[w_idx];
      w_gnt_idx = w_hit ? w_idx : w_gnt_idx;
      w_found   = w_found | w_hit;
    end
  end

  // Grant is only offered in IDLE; gating with reset keeps req_ready at zero
  // while reset is held even though the state register already reads IDLE.
  always_comb begin
    w_req_ready = '0;
    if ((r_state == IDLE) && w_found && reset) begin
      w_req_ready = NREQ'(1) << w_gnt_idx;
    end else begin
      w_req_ready = '0;
    end
  end

  assign w_accept = |(req_valid & w_req_ready);

  // Next-state logic for the IDLE -> ISSUE -> WAIT -> RESP sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_nxt = ISSUE;
        else          w_state_nxt = IDLE;
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (r_cnt == '0) w_state_nxt = RESP;
        else             w_state_nxt = WAIT;
      end
      RESP: begin
        if (resp_ready) w_state_nxt = IDLE;
        else            w_state_nxt = RESP;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand capture, start pulse, latency counter, response and pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rr_ptr     <= '0;
      r_gnt        <= '0;
      r_cnt        <= '0;
      r_fpu_a      <= 32'd0;
      r_fpu_b      <= 32'd0;
      r_fpu_sel    <= 2'd0;
      r_fpu_round  <= 1'b0;
      r_fpu_start  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_id    <= '0;
      r_resp_y     <= 32'd0;
      r_resp_err   <= 1'b0;
      r_resp_ovf   <= 1'b0;
`ifdef FPU_RR_ARB_STATS_EN
      r_stat_ops   <= 16'd0;
      r_stat_errs  <= 16'd0;
`endif
    end else begin
      // Start is high only in the cycle following the accept (the ISSUE cycle).
      r_fpu_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_fpu_a     <= req_a[32*w_gnt_idx +: 32];
            r_fpu_b     <= req_b[32*w_gnt_idx +: 32];
            r_fpu_sel   <= req_sel[2*w_gnt_idx +: 2];
            r_fpu_round <= req_round[w_gnt_idx];
            r_gnt       <= w_gnt_idx;
            r_fpu_start <= 1'b1;
          end
        end
        ISSUE: begin
          // WAIT then lasts FPU_LAT cycles, ending on the result-valid cycle.
          r_cnt <= CW'(FPU_LAT - 1);
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_resp_y     <= fpu_y;
            r_resp_err   <= fpu_error;
            r_resp_ovf   <= fpu_ovf;
            r_resp_id    <= IDW'(r_gnt);
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_resp_valid <= 1'b0;
            r_rr_ptr     <= (r_gnt == PW'(NREQ - 1)) ? '0 : r_gnt + PW'(1);
`ifdef FPU_RR_ARB_STATS_EN
            r_stat_ops <= r_stat_ops + 16'd1;
            if (r_resp_err | r_resp_ovf) r_stat_errs <= r_stat_errs + 16'd1;
`endif
          end
        end
        default: begin
          r_fpu_start <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = w_req_ready;
  assign fpu_a      = r_fpu_a;
  assign fpu_b      = r_fpu_b;
  assign fpu_sel    = r_fpu_sel;
  assign fpu_round  = r_fpu_round;
  assign fpu_start  = r_fpu_start;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_y     = r_resp_y;
  assign resp_error = r_resp_err;
  assign resp_ovf   = r_resp_ovf;
  assign busy       = (r_state != IDLE);
`ifdef FPU_RR_ARB_STATS_EN
  assign stat_ops   = r_stat_ops;
  assign stat_errs  = r_stat_errs;
`endif

endmodule

// File: tb/tb_fpu_rr_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for fpu_rr_arbiter. A stub FPU latches operands on fpu_start and
// presents a^b (error = sel==3, overflow = sel==2) exactly FPU_LAT cycles
// after the start cycle, and a poison value otherwise. Expected responses are
// queued as stimulus is issued; a monitor pops and compares them at each
// response handshake.
// -----------------------------------------------------------------------------
module tb_fpu_rr_arbiter;

  localparam int NREQ    = 4;
  localparam int FPU_LAT = 4;
  localparam int IDW     = 3;

  logic                clk;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [2*NREQ-1:0]   req_sel;
  logic [NREQ-1:0]     req_round;
  logic                resp_valid;
  logic                resp_ready;
  logic [IDW-1:0]      resp_id;
  logic [31:0]         resp_y;
  logic                resp_error;
  logic                resp_ovf;
  logic [31:0]         fpu_a;
  logic [31:0]         fpu_b;
  logic [1:0]          fpu_sel;
  logic                fpu_round;
  logic                fpu_start;
  logic [31:0]         fpu_y;
  logic                fpu_error;
  logic                fpu_ovf;
  logic                busy;
`ifdef FPU_RR_ARB_STATS_EN
  logic [15:0]         stat_ops;
  logic [15:0]         stat_errs;
`endif

  fpu_rr_arbiter #(.NREQ(NREQ), .FPU_LAT(FPU_LAT), .IDW(IDW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .req_round  (req_round),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_error (resp_error),
    .resp_ovf   (resp_ovf),
    .fpu_a      (fpu_a),
    .fpu_b      (fpu_b),
    .fpu_sel    (fpu_sel),
    .fpu_round  (fpu_round),
    .fpu_start  (fpu_start),
    .fpu_y      (fpu_y),
    .fpu_error  (fpu_error),
    .fpu_ovf    (fpu_ovf),
    .busy       (busy)
`ifdef FPU_RR_ARB_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_errs  (stat_errs)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- stub FPU ----------------
  logic        s_pend;
  logic [7:0]  s_cnt;
  logic [31:0] s_y;
  logic        s_err;
  logic        s_ovf;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_pend <= 1'b0;
      s_cnt  <= 8'd0;
      s_y    <= 32'd0;
      s_err  <= 1'b0;
      s_ovf  <= 1'b0;
    end else if (fpu_start) begin
      s_pend <= 1'b1;
      s_cnt  <= 8'(FPU_LAT - 1);
      s_y    <= fpu_a ^ fpu_b;
      s_err  <= (fpu_sel == 2'd3);
      s_ovf  <= (fpu_sel == 2'd2);
    end else if (s_cnt != 8'd0) begin
      s_cnt <= s_cnt - 8'd1;
    end
  end

  wire s_ok = s_pend && (s_cnt == 8'd0);
  assign fpu_y     = s_ok ? s_y : 32'hDEAD_BEEF;
  assign fpu_error = s_ok ? s_err : 1'b1;
  assign fpu_ovf   = s_ok ? s_ovf : 1'b1;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [IDW-1:0] id;
    logic [31:0]    y;
    logic           err;
    logic           ovf;
  } exp_t;

  exp_t expq[$];
  int   glog[$];
  int   n_cmp    = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   n_starts = 0;
  int   t_start  = 0;
  int   t_resp   = 0;
  int   exp_ops  = 0;
  int   exp_errs = 0;
  logic prev_rv  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] y, input logic err, input logic ovf);
    exp_t e;
    e.id  = IDW'(id);
    e.y   = y;
    e.err = err;
    e.ovf = ovf;
    expq.push_back(e);
  endtask

  // Cycle counter and grant log (accepts seen at the active edge).
  initial forever begin
    @(posedge clk);
    cyc++;
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) glog.push_back(i);
      end
    end
  end

  // Start-pulse counting and response-rise timing.
  initial forever begin
    @(negedge clk);
    if (fpu_start) begin
      n_starts++;
      t_start = cyc;
    end
    if (resp_valid && !prev_rv) t_resp = cyc;
    prev_rv = resp_valid;
  end

  // Response monitor: compares each handshake with the head of the queue.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!reset) begin
      exp_ops  = 0;
      exp_errs = 0;
    end else if (resp_valid && resp_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL resp_unexpected: got id %0d y 0x%08h with nothing expected", resp_id, resp_y);
      end else begin
        e = expq.pop_front();
        chk("resp_id",    32'(resp_id),    32'(e.id));
        chk("resp_y",     resp_y,          e.y);
        chk("resp_error", 32'(resp_error), 32'(e.err));
        chk("resp_ovf",   32'(resp_ovf),   32'(e.ovf));
        exp_ops++;
        if (e.err | e.ovf) exp_errs++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic raise(input int i, input logic [31:0] a, input logic [31:0] b, input logic [1:0] sel);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_sel[2*i +: 2] = sel;
    req_round[i]      = sel[0];
    req_valid[i]      = 1'b1;
  endtask

  task automatic wait_accept(input int i);
    logic got;
    got = 1'b0;
    for (int c = 0; c < 200 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    chk("accept_in_time", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (!busy && expq.size() == 0) done = 1'b1;
    end
    chk("idle_in_time", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int   s0;
    logic got;
    reset      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sel    = '0;
    req_round  = '0;
    resp_ready = 1'b1;

    // Reset state, with a request pending that must not see ready.
    req_valid[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready",  32'(req_ready),  32'd0);
    chk("rst_busy",       32'(busy),       32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_fpu_start",  32'(fpu_start),  32'd0);
    chk("rst_fpu_a",      fpu_a,           32'd0);
    chk("rst_resp_y",     resp_y,          32'd0);
    req_valid[1] = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single request on lane 2: one start, FPU_LAT+1 cycles to the response.
    s0 = n_starts;
    push_exp(2, 32'h7F80_0000, 1'b0, 1'b0);
    raise(2, 32'h3F80_0000, 32'h4000_0000, 2'd0);
    wait_accept(2);
    wait_idle();
    chk("t1_start_count", 32'(n_starts - s0), 32'd1);
    chk("t1_latency",     32'(t_resp - t_start), 32'(FPU_LAT + 1));
    chk("t1_fpu_a_held",  fpu_a, 32'h3F80_0000);

    // Reset in the middle of WAIT abandons the operation.
    raise(3, 32'h1234_5678, 32'h0000_0000, 2'd1);
    wait_accept(3);
    repeat (2) @(posedge clk);
    #1;
    chk("midop_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy",       32'(busy),       32'd0);
    chk("abort_fpu_start",  32'(fpu_start),  32'd0);
    chk("abort_fpu_a",      fpu_a,           32'd0);
    chk("abort_fpu_b",      fpu_b,           32'd0);
    chk("abort_fpu_sel",    32'(fpu_sel),    32'd0);
    chk("abort_fpu_round",  32'(fpu_round),  32'd0);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_resp_y",     resp_y,          32'd0);
    chk("abort_resp_id",    32'(resp_id),    32'd0);
    chk("abort_resp_flags", 32'({resp_error, resp_ovf}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All four lanes held valid: grants 0,1,2,3,0 from a fresh pointer.
    glog.delete();
    s0 = n_starts;
    push_exp(0, 32'h0000_0FF0, 1'b0, 1'b0);
    push_exp(1, 32'hEDCB_5678, 1'b0, 1'b0);
    push_exp(2, 32'hFFFF_FFFF, 1'b0, 1'b0);
    push_exp(3, 32'h8000_0000, 1'b0, 1'b0);
    push_exp(0, 32'h0000_0FF0, 1'b0, 1'b0);
    raise(0, 32'h0000_00FF, 32'h0000_0F0F, 2'd0);
    raise(1, 32'h1234_5678, 32'hFFFF_0000, 2'd0);
    raise(2, 32'hAAAA_AAAA, 32'h5555_5555, 2'd0);
    raise(3, 32'h8000_0001, 32'h0000_0001, 2'd1);
    got = 1'b0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(posedge clk);
      #1;
      if (glog.size() >= 5) got = 1'b1;
    end
    req_valid = '0;
    chk("rr_five_grants", 32'(got), 32'd1);
    wait_idle();
    chk("rr_grant_count", 32'(glog.size()), 32'd5);
    if (glog.size() == 5) begin
      chk("rr_grant0", 32'(glog[0]), 32'd0);
      chk("rr_grant1", 32'(glog[1]), 32'd1);
      chk("rr_grant2", 32'(glog[2]), 32'd2);
      chk("rr_grant3", 32'(glog[3]), 32'd3);
      chk("rr_grant4", 32'(glog[4]), 32'd0);
    end
    chk("rr_start_count", 32'(n_starts - s0), 32'd5);

    // Back-pressure: response held 10 cycles, no grant meanwhile.
    resp_ready = 1'b0;
    push_exp(2, 32'hCAFE_BABE, 1'b0, 1'b0);
    raise(2, 32'hCAFE_0000, 32'h0000_BABE, 2'd0);
    wait_accept(2);
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (resp_valid) got = 1'b1;
    end
    chk("bp_resp_seen", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    raise(0, 32'h0F0F_0F0F, 32'h0000_0000, 2'd0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_resp_valid", 32'(resp_valid), 32'd1);
      chk("bp_resp_y",     resp_y,          32'hCAFE_BABE);
      chk("bp_resp_id",    32'(resp_id),    32'd2);
      chk("bp_req_ready",  32'(req_ready),  32'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    push_exp(0, 32'h0F0F_0F0F, 1'b0, 1'b0);
    wait_accept(0);
    wait_idle();

    // Error flag (sel=3) and overflow flag (sel=2).
    push_exp(1, 32'h0000_0003, 1'b1, 1'b0);
    raise(1, 32'h0000_0001, 32'h0000_0002, 2'd3);
    wait_accept(1);
    push_exp(2, 32'h0000_0011, 1'b0, 1'b1);
    raise(2, 32'h0000_0010, 32'h0000_0001, 2'd2);
    wait_accept(2);
    wait_idle();

    // Lane 1 withdraws before accept while lane 3 waits: lane 3 wins.
    glog.delete();
    push_exp(0, 32'hA5A5_5A5A, 1'b0, 1'b0);
    raise(0, 32'hA5A5_0000, 32'h0000_5A5A, 2'd0);
    wait_accept(0);
    raise(1, 32'h0000_0BAD, 32'h0000_0000, 2'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    push_exp(3, 32'h0000_0000, 1'b0, 1'b0);
    raise(3, 32'h0000_0001, 32'h0000_0001, 2'd0);
    wait_accept(3);
    wait_idle();
    chk("drop_grant_count", 32'(glog.size()), 32'd2);
    if (glog.size() == 2) begin
      chk("drop_grant_last", 32'(glog[1]), 32'd3);
    end

`ifdef FPU_RR_ARB_STATS_EN
    chk("stat_ops",  32'(stat_ops),  32'(exp_ops));
    chk("stat_errs", 32'(stat_errs), 32'(exp_errs));
`endif
    chk("queue_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
